// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DIV_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 4;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag, registered tick and clk_out.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DEF_DIV - 1);

    logic [DIV_W-1:0] cnt, div_act, div_shd;
    logic [DIV_W-1:0] cnt_nx, div_nx;
    logic             run, boundary, apply, tick_nx, clk_out_nx;

    always_comb begin
        run      = en && (div_act != '0);
        boundary = 1'b0;
        div_nx   = div_act;
        cnt_nx   = cnt;
        if (run) begin
            boundary = sync || (cnt == div_act - ONE);
            if (boundary) begin
                cnt_nx = '0;
                if (pending) div_nx = div_shd;
            end else begin
                cnt_nx = cnt + ONE;
            end
        end else begin
            if (pending) div_nx = div_shd;
            // Park one step before the wrap so the first running edge is a boundary.
            cnt_nx = (div_nx == '0) ? '0 : div_nx - ONE;
        end
        apply      = pending && (boundary || !run);
        tick_nx    = run && boundary;
        clk_out_nx = run && (cnt_nx < (div_nx >> 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= RST_CNT;
            div_act <= RST_DIV;
            div_shd <= RST_DIV;
            pending <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            div_act <= div_nx;
            tick    <= tick_nx;
            clk_out <= clk_out_nx;
            // wr is only granted while nothing is pending, so it never races apply.
            if (wr) begin
                div_shd <= wr_div;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / clock-enable generator.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH-1:0]       en,
    input  logic                  sync,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ch_w(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick
);

    localparam int CH_W   = ch_w(N_CH);
    localparam int N_SLOT = 1 << CH_W;

    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   wr;
    logic [N_SLOT-1:0] pend_slot;

    // Unimplemented channel numbers read as ready; writes to them are dropped.
    always_comb begin
        pend_slot            = '0;
        pend_slot[N_CH-1:0]  = pend;
    end

    assign cfg_ready = !pend_slot[cfg_ch];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .pending (pend[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed table, corner sequences and random traffic.
module tb_clk_div_gen;

    localparam int N_CH    = 4;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int n_chk = 0;
    int n_err = 0;

    // Reference: each channel is a period, a position inside it, an "armed" flag
    // (next running edge starts a period) and at most one queued divisor.
    int         m_per [4];
    int         m_ph  [4];
    bit         m_arm [4];
    bit         m_has [4];
    int         m_val [4];
    logic [3:0] exp_tick, exp_clk;
    logic       last_rdy;

    typedef struct {
        logic [3:0] en;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
    } vec_t;
    vec_t tbl [11];

    clk_div_gen #(
        .N_CH    (N_CH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_per[i] = DEF_DIV;
            m_ph[i]  = 0;
            m_arm[i] = 1'b1;
            m_has[i] = 1'b0;
            m_val[i] = DEF_DIV;
        end
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = !m_has[cfg_ch];
        for (int i = 0; i < 4; i++) begin
            bit running, start;
            running = en[i] && (m_per[i] > 0);
            start   = 1'b0;
            if (running) begin
                if (sync || m_arm[i] || (m_ph[i] + 1 == m_per[i])) begin
                    start    = 1'b1;
                    m_ph[i]  = 0;
                    m_arm[i] = 1'b0;
                    if (m_has[i]) begin
                        m_per[i] = m_val[i];
                        m_has[i] = 1'b0;
                    end
                end else begin
                    m_ph[i]++;
                end
            end else begin
                m_arm[i] = 1'b1;
                m_ph[i]  = 0;
                if (m_has[i]) begin
                    m_per[i] = m_val[i];
                    m_has[i] = 1'b0;
                end
            end
            exp_tick[i] = start;
            exp_clk[i]  = running && (m_ph[i] < m_per[i] / 2);
        end
        if (cfg_valid && rdy) begin
            m_has[cfg_ch] = 1'b1;
            m_val[cfg_ch] = int'(cfg_div);
        end
    endtask

    task automatic step();
        #1;
        last_rdy = cfg_ready;
        chk("cfg_ready", {7'd0, cfg_ready}, {7'd0, !m_has[cfg_ch]});
        @(posedge CLK);
        model_edge();
        #1;
        chk("tick", {4'd0, tick}, {4'd0, exp_tick});
        chk("clk_out", {4'd0, clk_out}, {4'd0, exp_clk});
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < max);
        if (!tick[ch]) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles, required one", ch, max);
        end
    endtask

    task automatic collect(input int ch, input int nb, input bit use_tick, output logic [7:0] bits);
        bits = {7'd0, use_tick ? tick[ch] : clk_out[ch]};
        for (int k = 1; k < nb; k++) begin
            step();
            bits = {bits[6:0], use_tick ? tick[ch] : clk_out[ch]};
        end
    endtask

    task automatic write_until_accepted(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_rdy && n < max);
        if (!last_rdy) begin
            n_chk++;
            n_err++;
            $display("FAIL write_accept ch%0d: not accepted within %0d cycles", cfg_ch, max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [7:0]  bits;

        tbl[0]  = '{4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'hF, 4'hF, 4'hF};
        tbl[2]  = '{4'hF, 4'hF, 4'h0};
        tbl[3]  = '{4'hF, 4'h0, 4'h0};
        tbl[4]  = '{4'hF, 4'h0, 4'h0};
        tbl[5]  = '{4'hF, 4'hF, 4'hF};
        tbl[6]  = '{4'hF, 4'hF, 4'h0};
        tbl[7]  = '{4'hF, 4'h0, 4'h0};
        tbl[8]  = '{4'hF, 4'h0, 4'h0};
        tbl[9]  = '{4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'hF, 4'hF, 4'hF};

        en = 4'h0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        last_rdy = 1'b1;
        model_reset();

        #3;
        chk("reset_tick", {4'd0, tick}, 8'h00);
        chk("reset_clk_out", {4'd0, clk_out}, 8'h00);
        chk("reset_ready", {7'd0, cfg_ready}, 8'h01);
        #19 RST_N = 1'b1;

        // Default divide-by-4 from reset, en drop re-arms, en rise ticks at once.
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en;
            step();
            chk("tbl_tick", {4'd0, tick}, {4'd0, tbl[i].exp_tick});
            chk("tbl_clk_out", {4'd0, clk_out}, {4'd0, tbl[i].exp_clk});
        end

        // ch1 -> 3 mid-period: held off until the boundary, then clean 100.
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0;
        chk("t2_ready_low", {7'd0, cfg_ready}, 8'h00);
        wait_tick(1, 8, n);
        collect(1, 6, 1'b0, bits);
        chk("t2_pattern", bits, 8'b0010_0100);

        // ch2 -> 0 then 6 held on the bus: stop, then restart as 111000.
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        step();
        cfg_div = 8'd6;
        write_until_accepted(20, n);
        cfg_valid = 1'b0;
        chk("t3_stalled", {7'd0, n > 1}, 8'h01);
        wait_tick(2, 12, n);
        chk("t3_restart_gap", 8'(n), 8'd2);
        collect(2, 6, 1'b0, bits);
        chk("t3_pattern", bits, 8'b0011_1000);

        // ch3 -> 5, then sync mid-period aligns everything; sync on a boundary ticks once.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        repeat (7) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t4_sync_ticks", {4'd0, tick}, 8'h0F);
        wait_tick(0, 8, n);
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        collect(0, 5, 1'b1, bits);
        chk("t4_single_tick", bits, 8'b0001_0001);

        // Back-to-back ch1 writes with valid held: 5 then 2, applied in order.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        write_until_accepted(10, n);
        cfg_div = 8'd2;
        write_until_accepted(20, n);
        cfg_valid = 1'b0;
        chk("t5_stall", {7'd0, n > 1}, 8'h01);
        wait_tick(1, 10, n);
        chk("t5_gap_div5", 8'(n), 8'd4);
        wait_tick(1, 10, n);
        chk("t5_gap_div2", 8'(n), 8'd2);

        // Async reset mid-period with a write pending on ch1.
        wait_tick(0, 8, n);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
        step();
        cfg_valid = 1'b0;
        chk("t6_pre_clk_out0", {7'd0, clk_out[0]}, 8'h01);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_rst_tick", {4'd0, tick}, 8'h00);
        chk("t6_rst_clk_out", {4'd0, clk_out}, 8'h00);
        chk("t6_rst_ready", {7'd0, cfg_ready}, 8'h01);
        model_reset();
        @(posedge CLK);
        #2 RST_N = 1'b1;
        step();
        chk("t6_first_tick", {4'd0, tick}, 8'h0F);
        wait_tick(1, 8, n);
        chk("t6_def_period", 8'(n), 8'd4);

        // Random traffic against the reference.
        for (int c = 0; c < 1500; c++) begin
            int b;
            if ($urandom_range(0, 49) == 0) begin
                b = $urandom_range(0, 3);
                en[b] = ~en[b];
            end
            sync = ($urandom_range(0, 39) == 0);
            if (!cfg_valid || last_rdy) begin
                cfg_valid = ($urandom_range(0, 2) == 0);
                cfg_ch    = 2'($urandom_range(0, 3));
                cfg_div   = 8'($urandom_range(0, 9));
            end
            step();
        end
        sync = 1'b0;
        cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
